// File: rtl/param_stack.sv
// param_stack: parametrised LIFO with registered top-of-stack, count, clear and error flags.
// Define PARAM_STACK_STICKY_ERR_EN to make overflow/underflow sticky until reset or clear.
module param_stack #(
    parameter int DATA_W = 14,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] L_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] L_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] L_TWO  = CNT_W'(2);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_dout;
    logic              r_empty, r_full, r_ovf, r_unf;

    logic              w_is_empty, w_is_full;
    logic              w_push_new, w_replace, w_pop, w_ovf_ev, w_unf_ev, w_wr;
    logic [AW-1:0]     w_wr_idx, w_rd_idx;
    logic [CNT_W-1:0]  w_nxt_cnt;
    logic [DATA_W-1:0] w_pop_data, w_nxt_dout;

    // push+pop on an empty stack degrades to a plain push
    always_comb begin
        w_is_empty = (r_cnt == '0);
        w_is_full  = (r_cnt == L_FULL);
        w_push_new = push && (pop ? w_is_empty : !w_is_full);
        w_replace  = push && pop && !w_is_empty;
        w_pop      = pop && !push && !w_is_empty;
        w_ovf_ev   = push && !pop && w_is_full;
        w_unf_ev   = pop && !push && w_is_empty;
        w_wr       = w_push_new || w_replace;
        w_wr_idx   = AW'(w_replace ? r_cnt - L_ONE : r_cnt);
        w_rd_idx   = AW'(r_cnt - L_TWO);
        w_pop_data = (r_cnt >= L_TWO) ? r_mem[w_rd_idx] : '0;
        w_nxt_cnt  = w_push_new ? r_cnt + L_ONE : w_pop ? r_cnt - L_ONE : r_cnt;
        w_nxt_dout = w_wr ? data_in : w_pop ? w_pop_data : r_dout;
    end

    always_ff @(posedge clk)
        if (reset && !clear && w_wr)
            r_mem[w_wr_idx] <= data_in;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            r_cnt   <= '0;
            r_dout  <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_cnt   <= w_nxt_cnt;
            r_dout  <= w_nxt_dout;
            r_empty <= (w_nxt_cnt == '0);
            r_full  <= (w_nxt_cnt == L_FULL);
`ifdef PARAM_STACK_STICKY_ERR_EN
            r_ovf   <= r_ovf | w_ovf_ev;
            r_unf   <= r_unf | w_unf_ev;
`else
            r_ovf   <= w_ovf_ev;
            r_unf   <= w_unf_ev;
`endif
        end
    end

    assign data_out  = r_dout;
    assign count     = r_cnt;
    assign empty     = r_empty;
    assign full      = r_full;
    assign overflow  = r_ovf;
    assign underflow = r_unf;
endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: directed scoreboard bench for param_stack (DEPTH=4, DATA_W=14, default build).
module tb_param_stack;
    typedef struct packed {
        logic [13:0] d;
        logic [2:0]  c;
        logic        e, f, o, u;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, clear, push, pop;
    logic [13:0] data_in;
    logic [13:0] data_out;
    logic [2:0]  count;
    logic        empty, full, overflow, underflow;
    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;

    param_stack #(.DATA_W(14), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .clear(clear), .push(push), .pop(pop),
        .data_in(data_in), .data_out(data_out), .count(count), .empty(empty),
        .full(full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one clock: drive request, queue its expected outcome, compare after the edge
    task automatic step(input logic rn, cl, pu, po, input logic [13:0] din,
                        input logic [13:0] ed, input logic [2:0] ec,
                        input logic ee, ef, eo, eu);
        exp_t x;
        reset = rn; clear = cl; push = pu; pop = po; data_in = din;
        q.push_back('{d: ed, c: ec, e: ee, f: ef, o: eo, u: eu});
        @(posedge clk);
        #1;
        x = q.pop_front();
        chk("data_out", data_out, x.d);
        chk("count", 14'(count), 14'(x.c));
        chk("empty", 14'(empty), 14'(x.e));
        chk("full", 14'(full), 14'(x.f));
        chk("overflow", 14'(overflow), 14'(x.o));
        chk("underflow", 14'(underflow), 14'(x.u));
    endtask

    initial begin
        //    rn cl pu po din       d        c  e  f  o  u
        step(0, 0, 0, 0, 14'h0000, 14'h0000, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 14'h1234, 14'h0000, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 14'h0011, 14'h0011, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 14'h0022, 14'h0022, 2, 0, 0, 0, 0);
        step(1, 0, 1, 0, 14'h0033, 14'h0033, 3, 0, 0, 0, 0);
        step(1, 0, 1, 0, 14'h0044, 14'h0044, 4, 0, 1, 0, 0);
        step(1, 0, 1, 0, 14'h3FFF, 14'h0044, 4, 0, 1, 1, 0);
        step(1, 0, 1, 0, 14'h3FFF, 14'h0044, 4, 0, 1, 1, 0);
        step(1, 0, 0, 0, 14'h2AAA, 14'h0044, 4, 0, 1, 0, 0);
        step(1, 0, 0, 1, 14'h1111, 14'h0033, 3, 0, 0, 0, 0);
        step(1, 0, 0, 1, 14'h0000, 14'h0022, 2, 0, 0, 0, 0);
        step(1, 0, 0, 1, 14'h0000, 14'h0011, 1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 14'h0000, 14'h0000, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 14'h0000, 14'h0000, 0, 1, 0, 0, 1);
        step(1, 0, 0, 0, 14'h0000, 14'h0000, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 14'h0011, 14'h0011, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 14'h0022, 14'h0022, 2, 0, 0, 0, 0);
        step(1, 0, 1, 1, 14'h0155, 14'h0155, 2, 0, 0, 0, 0);
        step(1, 0, 0, 1, 14'h0000, 14'h0011, 1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 14'h0000, 14'h0000, 0, 1, 0, 0, 0);
        step(1, 0, 1, 1, 14'h0077, 14'h0077, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 14'h00A1, 14'h00A1, 2, 0, 0, 0, 0);
        step(1, 0, 1, 0, 14'h00A2, 14'h00A2, 3, 0, 0, 0, 0);
        step(1, 0, 1, 0, 14'h00A3, 14'h00A3, 4, 0, 1, 0, 0);
        step(1, 0, 1, 1, 14'h0123, 14'h0123, 4, 0, 1, 0, 0);
        step(1, 0, 0, 1, 14'h0000, 14'h00A2, 3, 0, 0, 0, 0);
        step(1, 0, 0, 1, 14'h0000, 14'h00A1, 2, 0, 0, 0, 0);
        step(1, 0, 0, 1, 14'h0000, 14'h0077, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 14'h0B01, 14'h0B01, 2, 0, 0, 0, 0);
        step(1, 0, 1, 0, 14'h0B02, 14'h0B02, 3, 0, 0, 0, 0);
        step(1, 1, 1, 0, 14'h03FF, 14'h0000, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 14'h0000, 14'h0000, 0, 1, 0, 0, 1);
        step(1, 1, 0, 0, 14'h0000, 14'h0000, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 14'h0C01, 14'h0C01, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 14'h0C02, 14'h0C02, 2, 0, 0, 0, 0);
        step(1, 0, 1, 0, 14'h0C03, 14'h0C03, 3, 0, 0, 0, 0);
        step(0, 0, 1, 0, 14'h0C04, 14'h0000, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 14'h2AB0, 14'h2AB0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 14'h0000, 14'h0000, 0, 1, 0, 0, 0);
        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed %0d expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
